// File: rtl/data_hs_rx_ctl.sv
// HS receive controller for one D-PHY data lane: leader hunt, LSB-first byte
// assembly, 32-bit PPI word packing, LP-stop flush and SoT error reporting.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   hs_rx_en         rising edge arms reception, low level aborts
//   lp_stop          LP-11 seen on the lane, ends the burst
//   hs_bit_valid     qualifies hs_bit
//   hs_bit           deserialized HS line bit
//   rx_data_hs       received word, byte0 in [7:0]
//   rx_valid_hs      per-byte valid pulse
//   rx_active_hs     burst in progress
//   rx_sync_hs       sync found pulse
//   err_sot_hs       sync accepted with one bit error
//   err_sot_sync_hs  sync timeout pulse
//   rx_byte_cnt      bytes delivered in the current burst (saturating)
module data_hs_rx_ctl #(
  parameter logic [7:0]  SYNC_PATTERN = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 64,
  parameter int unsigned ERR_TOL      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_rx_en,
  input  logic        lp_stop,
  input  logic        hs_bit_valid,
  input  logic        hs_bit,
  output logic [31:0] rx_data_hs,
  output logic [3:0]  rx_valid_hs,
  output logic        rx_active_hs,
  output logic        rx_sync_hs,
  output logic        err_sot_hs,
  output logic        err_sot_sync_hs,
  output logic [15:0] rx_byte_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC_HUNT,
    RECEIVE,
    ERR_WAIT
  } state_e;

  state_e      state_q;
  logic        en_q;
  logic [7:0]  sh_q;
  logic [9:0]  to_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  byte_q;
  logic [31:0] word_q;
  logic [31:0] data_q;
  logic [3:0]  valid_q;
  logic        active_q;
  logic        sync_q;
  logic        err_q;
  logic        tmo_q;
  logic [15:0] cnt_q;

  logic [7:0]  win_d;
  logic [7:0]  byte_d;
  logic [9:0]  to_cnt_d;
  logic [3:0]  dist_d;
  logic        match_d;
  logic [3:0]  fmask_d;
  logic [31:0] fdata_d;

  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [2:0]  n
  );
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign win_d    = {hs_bit, sh_q[7:1]};
  assign byte_d   = {hs_bit, byte_q[7:1]};
  assign to_cnt_d = to_cnt_q + 10'd1;
  assign match_d  = (dist_d <= 4'(ERR_TOL));

  always_comb begin
    dist_d = '0;
    for (int i = 0; i < 8; i++) begin
      dist_d = dist_d + {3'd0, win_d[i] ^ SYNC_PATTERN[i]};
    end
  end

  // Only completed bytes are flushed; the rest read as zero.
  always_comb begin
    fmask_d = 4'b0000;
    case (byte_idx_q)
      2'd1:    fmask_d = 4'b0001;
      2'd2:    fmask_d = 4'b0011;
      2'd3:    fmask_d = 4'b0111;
      default: fmask_d = 4'b0000;
    endcase
  end

  always_comb begin
    fdata_d = '0;
    for (int i = 0; i < 4; i++) begin
      fdata_d[8*i +: 8] = fmask_d[i] ? word_q[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      sh_q       <= 8'hFF;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      byte_q     <= '0;
      word_q     <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      active_q   <= 1'b0;
      sync_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      en_q    <= hs_rx_en;
      valid_q <= '0;
      sync_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      if (state_q == IDLE) begin
        if (hs_rx_en && !en_q) begin
          state_q  <= SYNC_HUNT;
          sh_q     <= 8'hFF;
          to_cnt_q <= '0;
          cnt_q    <= '0;
        end
      end else if (!hs_rx_en) begin
        // Abort: drop partial data, keep the byte count.
        state_q    <= IDLE;
        active_q   <= 1'b0;
        bit_cnt_q  <= '0;
        byte_idx_q <= '0;
      end else begin
        case (state_q)
          SYNC_HUNT: begin
            if (lp_stop) begin
              state_q <= IDLE;
            end else if (hs_bit_valid) begin
              sh_q <= win_d;
              if (match_d) begin
                state_q    <= RECEIVE;
                sync_q     <= 1'b1;
                err_q      <= (dist_d != 4'd0);
                active_q   <= 1'b1;
                bit_cnt_q  <= '0;
                byte_idx_q <= '0;
              end else begin
                to_cnt_q <= to_cnt_d;
                if (to_cnt_d == 10'(SYNC_TIMEOUT)) begin
                  tmo_q   <= 1'b1;
                  state_q <= ERR_WAIT;
                end
              end
            end
          end
          RECEIVE: begin
            if (lp_stop) begin
              if (byte_idx_q != 2'd0) begin
                valid_q <= fmask_d;
                data_q  <= fdata_d;
                cnt_q   <= sat_add(cnt_q, {1'b0, byte_idx_q});
              end
              state_q    <= IDLE;
              active_q   <= 1'b0;
              bit_cnt_q  <= '0;
              byte_idx_q <= '0;
            end else if (hs_bit_valid) begin
              byte_q    <= byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                word_q[8*byte_idx_q +: 8] <= byte_d;
                byte_idx_q <= byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                  data_q  <= {byte_d, word_q[23:0]};
                  valid_q <= 4'b1111;
                  cnt_q   <= sat_add(cnt_q, 3'd4);
                end
              end
            end
          end
          ERR_WAIT: begin
            if (lp_stop) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_data_hs      = data_q;
  assign rx_valid_hs     = valid_q;
  assign rx_active_hs    = active_q;
  assign rx_sync_hs      = sync_q;
  assign err_sot_hs      = err_q;
  assign err_sot_sync_hs = tmo_q;
  assign rx_byte_cnt     = cnt_q;

endmodule

// File: tb/tb_data_hs_rx_ctl.sv
// Bench for data_hs_rx_ctl: burst table, corner sequences and stalled
// random bursts, each cycle checked against a queue-based lane model.
module tb_data_hs_rx_ctl;

  logic        clk;
  logic        rst;
  logic        hs_rx_en;
  logic        lp_stop;
  logic        hs_bit_valid;
  logic        hs_bit;
  logic [31:0] rx_data_hs;
  logic [3:0]  rx_valid_hs;
  logic        rx_active_hs;
  logic        rx_sync_hs;
  logic        err_sot_hs;
  logic        err_sot_sync_hs;
  logic [15:0] rx_byte_cnt;

  logic [31:0] u1_data;
  logic [3:0]  u1_valid;
  logic        u1_active;
  logic        u1_sync;
  logic        u1_err;
  logic        u1_tmo;
  logic [15:0] u1_cnt;

  data_hs_rx_ctl dut (
    .clk(clk), .rst(rst), .hs_rx_en(hs_rx_en),
    .lp_stop(lp_stop), .hs_bit_valid(hs_bit_valid),
    .hs_bit(hs_bit), .rx_data_hs(rx_data_hs),
    .rx_valid_hs(rx_valid_hs), .rx_active_hs(rx_active_hs),
    .rx_sync_hs(rx_sync_hs), .err_sot_hs(err_sot_hs),
    .err_sot_sync_hs(err_sot_sync_hs), .rx_byte_cnt(rx_byte_cnt)
  );

  data_hs_rx_ctl #(.ERR_TOL(0)) u1 (
    .clk(clk), .rst(rst), .hs_rx_en(hs_rx_en),
    .lp_stop(lp_stop), .hs_bit_valid(hs_bit_valid),
    .hs_bit(hs_bit), .rx_data_hs(u1_data),
    .rx_valid_hs(u1_valid), .rx_active_hs(u1_active),
    .rx_sync_hs(u1_sync), .err_sot_hs(u1_err),
    .err_sot_sync_hs(u1_tmo), .rx_byte_cnt(u1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Lane model: spec rules over queues of bits and bytes.
  localparam int M_IDLE = 0;
  localparam int M_HUNT = 1;
  localparam int M_RECV = 2;
  localparam int M_ERRW = 3;
  int          m_mode;
  logic        m_en_prev;
  logic [7:0]  m_win;
  int          m_tcount;
  logic        m_bits[$];
  logic [7:0]  m_bytes[$];
  logic [31:0] e_data;
  logic [3:0]  e_valid;
  logic        e_active, e_sync, e_err, e_tmo;
  int          e_cnt;

  function automatic logic [31:0] pack_bytes(input logic [7:0] q[$]);
    logic [31:0] w;
    w = '0;
    foreach (q[i]) w = w | (32'(q[i]) << (8 * i));
    return w;
  endfunction

  task automatic m_step(input logic r, en, lp, v, b);
    int d;
    logic [7:0] by;
    if (r) begin
      m_mode = M_IDLE; m_en_prev = 0; m_win = 8'hFF; m_tcount = 0;
      m_bits.delete(); m_bytes.delete();
      e_data = 0; e_valid = 0; e_active = 0;
      e_sync = 0; e_err = 0; e_tmo = 0; e_cnt = 0;
      return;
    end
    e_valid = 0; e_sync = 0; e_err = 0; e_tmo = 0;
    if (m_mode == M_IDLE) begin
      if (en && !m_en_prev) begin
        m_mode = M_HUNT; m_win = 8'hFF; m_tcount = 0; e_cnt = 0;
      end
    end else if (!en) begin
      m_mode = M_IDLE; e_active = 0;
      m_bits.delete(); m_bytes.delete();
    end else if (m_mode == M_HUNT) begin
      if (lp) m_mode = M_IDLE;
      else if (v) begin
        m_win = {b, m_win[7:1]};
        d = $countones(m_win ^ 8'hB8);
        if (d <= 1) begin
          m_mode = M_RECV; e_sync = 1; e_err = (d == 1); e_active = 1;
          m_bits.delete(); m_bytes.delete();
        end else begin
          m_tcount++;
          if (m_tcount == 64) begin
            e_tmo = 1; m_mode = M_ERRW;
          end
        end
      end
    end else if (m_mode == M_RECV) begin
      if (lp) begin
        if (m_bytes.size() > 0) begin
          e_data = pack_bytes(m_bytes);
          e_valid = 4'((1 << m_bytes.size()) - 1);
          e_cnt = (e_cnt + m_bytes.size() > 65535) ? 65535
                : e_cnt + m_bytes.size();
        end
        m_bits.delete(); m_bytes.delete();
        e_active = 0; m_mode = M_IDLE;
      end else if (v) begin
        m_bits.push_back(b);
        if (m_bits.size() == 8) begin
          by = 0;
          foreach (m_bits[i]) by[i] = m_bits[i];
          m_bits.delete();
          m_bytes.push_back(by);
          if (m_bytes.size() == 4) begin
            e_data = pack_bytes(m_bytes);
            e_valid = 4'hF;
            e_cnt = (e_cnt + 4 > 65535) ? 65535 : e_cnt + 4;
            m_bytes.delete();
          end
        end
      end
    end else begin
      if (lp) m_mode = M_IDLE;
    end
    m_en_prev = en;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scenario monitors.
  int          n_sync, n_err, n_tmo, n_words, n_flush, u1s, u1t;
  logic [3:0]  f_mask;
  logic [31:0] f_data;
  logic [31:0] got_words[$];
  int          word_cyc[$];

  task automatic clr_mon();
    n_sync = 0; n_err = 0; n_tmo = 0; n_words = 0; n_flush = 0;
    u1s = 0; u1t = 0; f_mask = 0; f_data = 0;
    got_words.delete(); word_cyc.delete();
  endtask

  task automatic step(input logic r, en, lp, v, b);
    rst = r; hs_rx_en = en; lp_stop = lp; hs_bit_valid = v; hs_bit = b;
    @(posedge clk);
    m_step(r, en, lp, v, b);
    @(negedge clk);
    cyc++;
    check("cycle",
      {6'd0, rx_data_hs, rx_valid_hs, rx_active_hs, rx_sync_hs,
       err_sot_hs, err_sot_sync_hs, rx_byte_cnt},
      {6'd0, e_data, e_valid, e_active, e_sync, e_err, e_tmo,
       16'(e_cnt)});
    if (rx_sync_hs) n_sync++;
    if (err_sot_hs) n_err++;
    if (err_sot_sync_hs) n_tmo++;
    if (u1_sync) u1s++;
    if (u1_tmo) u1t++;
    if (rx_valid_hs == 4'hF) begin
      n_words++;
      got_words.push_back(rx_data_hs);
      word_cyc.push_back(cyc);
    end else if (rx_valid_hs != 4'h0) begin
      n_flush++; f_mask = rx_valid_hs; f_data = rx_data_hs;
    end
  endtask

  int gap_pct = 0;

  task automatic send(input logic [31:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct)
        repeat ($urandom_range(1, 3))
          step(0, 1, 0, 0, 1'($urandom_range(1)));
      step(0, 1, 0, 1, val[i]);
    end
  endtask

  task automatic arm_and_lead(input logic [7:0] leader);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    send(32'd0, 16);
    send({24'd0, leader}, 8);
  endtask

  typedef struct {
    logic [7:0]  leader;
    logic [31:0] word;
    logic [31:0] tail;
    int          tail_bits;
    int          e_sync;
    int          e_err;
    int          e_tmo;
    int          e_words;
    logic [3:0]  e_fmask;
    logic [31:0] e_fdata;
    int          e_cnt;
    int          u1_sync;
    int          u1_tmo;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [31:0] sent[$];
    logic [31:0] tl;
    int tn;

    vt[0] = '{8'hB8, 32'hA5A5A5A5, 32'h12345678, 32,
              1, 0, 0, 2, 4'h0, 32'h0, 8, 1, 0};
    vt[1] = '{8'hB9, 32'h0F0F0F0F, 32'h0, 8,
              1, 1, 0, 1, 4'b0001, 32'h0, 5, 0, 1};
    vt[2] = '{8'h38, 32'h12345678, 32'h0, 16,
              1, 1, 0, 1, 4'b0011, 32'h0, 6, 0, 1};
    vt[3] = '{8'h00, 32'h0, 32'h0, 32,
              0, 0, 1, 0, 4'h0, 32'h0, 0, 0, 1};
    vt[4] = '{8'hB8, 32'hDEADBEEF, 32'h00152211, 21,
              1, 0, 0, 1, 4'b0011, 32'h00002211, 6, 1, 0};
    vt[5] = '{8'hB8, 32'hCAFEF00D, 32'h0, 0,
              1, 0, 0, 1, 4'h0, 32'h0, 4, 1, 0};

    rst = 1; hs_rx_en = 0; lp_stop = 0; hs_bit_valid = 0; hs_bit = 0;
    clr_mon();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_outputs",
      {6'd0, rx_data_hs, rx_valid_hs, rx_active_hs, rx_sync_hs,
       err_sot_hs, err_sot_sync_hs, rx_byte_cnt}, 64'd0);

    foreach (vt[k]) begin
      clr_mon();
      arm_and_lead(vt[k].leader);
      send(vt[k].word, 32);
      send(vt[k].tail, vt[k].tail_bits);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      check($sformatf("v%0d_sync", k), 64'(n_sync), 64'(vt[k].e_sync));
      check($sformatf("v%0d_err", k), 64'(n_err), 64'(vt[k].e_err));
      check($sformatf("v%0d_tmo", k), 64'(n_tmo), 64'(vt[k].e_tmo));
      check($sformatf("v%0d_words", k), 64'(n_words),
            64'(vt[k].e_words));
      check($sformatf("v%0d_fmask", k), 64'(f_mask),
            64'(vt[k].e_fmask));
      check($sformatf("v%0d_fdata", k), 64'(f_data),
            64'(vt[k].e_fdata));
      check($sformatf("v%0d_cnt", k), 64'(rx_byte_cnt),
            64'(vt[k].e_cnt));
      check($sformatf("v%0d_active", k), 64'(rx_active_hs), 64'd0);
      check($sformatf("v%0d_u1sync", k), 64'(u1s), 64'(vt[k].u1_sync));
      check($sformatf("v%0d_u1tmo", k), 64'(u1t), 64'(vt[k].u1_tmo));
      if (vt[k].e_words >= 1 && got_words.size() >= 1)
        check($sformatf("v%0d_word0", k), 64'(got_words[0]),
              64'(vt[k].word));
      if (vt[k].e_words == 2 && got_words.size() == 2) begin
        check($sformatf("v%0d_word1", k), 64'(got_words[1]),
              64'(vt[k].tail));
        check($sformatf("v%0d_spacing", k),
              64'(word_cyc[1] - word_cyc[0]), 64'd32);
      end
    end

    // Abort mid-word.
    clr_mon();
    arm_and_lead(8'hB8);
    send(32'hFFFFF5A3, 20);
    step(0, 0, 0, 0, 0);
    check("abort_active", 64'(rx_active_hs), 64'd0);
    check("abort_words", 64'(n_words + n_flush), 64'd0);
    check("abort_cnt", 64'(rx_byte_cnt), 64'd0);

    // Reset mid-word after one delivered word.
    clr_mon();
    arm_and_lead(8'hB8);
    send(32'h13579BDF, 32);
    send(32'hFFFFFFFF, 20);
    check("pre_rst_word", 64'(rx_data_hs), 64'h13579BDF);
    step(1, 1, 0, 0, 0);
    check("rst_outputs",
      {6'd0, rx_data_hs, rx_valid_hs, rx_active_hs, rx_sync_hs,
       err_sot_hs, err_sot_sync_hs, rx_byte_cnt}, 64'd0);
    step(0, 0, 0, 0, 0);

    // 32nd bit coincides with lp_stop: only three bytes flush.
    clr_mon();
    arm_and_lead(8'hB8);
    send(32'h44332211, 31);
    step(0, 1, 1, 1, 1'b0);
    step(0, 0, 0, 0, 0);
    check("simul_words", 64'(n_words), 64'd0);
    check("simul_fmask", 64'(f_mask), 64'b0111);
    check("simul_fdata", 64'(f_data), 64'h00332211);
    check("simul_cnt", 64'(rx_byte_cnt), 64'd3);

    // Stalled random bursts.
    gap_pct = 40;
    for (int it = 0; it < 4; it++) begin
      clr_mon();
      sent.delete();
      arm_and_lead(8'hB8);
      for (int j = 0; j < 4; j++) begin
        sent.push_back($urandom);
        send(sent[j], 32);
      end
      tl = $urandom;
      tn = $urandom_range(0, 31);
      send(tl, tn);
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      check($sformatf("rnd%0d_words", it), 64'(n_words), 64'd4);
      for (int j = 0; j < 4 && j < got_words.size(); j++)
        check($sformatf("rnd%0d_w%0d", it, j), 64'(got_words[j]),
              64'(sent[j]));
      check($sformatf("rnd%0d_cnt", it), 64'(rx_byte_cnt),
            64'(16 + tn / 8));
    end
    gap_pct = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
